// File: rtl/neopixel_rx.sv
// WS2812 ("NeoPixel") one-wire receiver: decodes 24-bit GRB pixels and frames from the serial line.
// Ports: clk/reset_n (async active-low); one_wire raw line in; pixel_data/pixel_valid/pixel_index
//        per decoded pixel; frame_done/pixel_count at each latch gap; error sticky until next frame_done.
// Optional: define NEOPIXEL_RX_GLITCH_FILTER_EN for a 3-sample majority filter (latency 3 -> 5 cycles).
module neopixel_rx #(
  parameter int unsigned BIT_THRESH_CYCLES = 32,
  parameter int unsigned MAX_HIGH_CYCLES   = 60,
  parameter int unsigned LATCH_CYCLES      = 2500
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        one_wire,
  output logic [23:0] pixel_data,
  output logic        pixel_valid,
  output logic [7:0]  pixel_index,
  output logic        frame_done,
  output logic [7:0]  pixel_count,
  output logic        error
);

  typedef enum logic [1:0] {ST_SYNC, ST_IDLE, ST_HIGH, ST_LOW} state_e;

  // The counter is cleared by the sample that detects an edge, so in HIGH/LOW it
  // lags the true number of line samples; the thresholds below absorb that offset.
  localparam logic [11:0] THRESH_M1 = 12'(BIT_THRESH_CYCLES - 1);
  localparam logic [11:0] MAX_HIGH  = 12'(MAX_HIGH_CYCLES);
  localparam logic [11:0] LATCH_M1  = 12'(LATCH_CYCLES - 1);
  localparam logic [11:0] LATCH_M2  = 12'(LATCH_CYCLES - 2);

  state_e      state_q, state_d;
  logic        sync1_q, sync2_q, line_prev_q;
  logic        line, rise, fall, bit_val;
  logic [11:0] cnt_q, cnt_d, cnt_inc;
  logic [22:0] shift_q, shift_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  idx_q, idx_d, idx_inc;
  logic [23:0] pixel_data_q, pixel_data_d;
  logic        pixel_valid_q, pixel_valid_d;
  logic [7:0]  pixel_index_q, pixel_index_d;
  logic        frame_done_q, frame_done_d;
  logic [7:0]  pixel_count_q, pixel_count_d;
  logic        error_q, error_d;

  // Input synchronizer
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= one_wire;
      sync2_q <= sync1_q;
    end
  end

`ifdef NEOPIXEL_RX_GLITCH_FILTER_EN
  // Majority of three consecutive samples; registered so both edges move by the same delay.
  logic hist0_q, hist1_q, filt_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hist0_q <= 1'b0;
      hist1_q <= 1'b0;
      filt_q  <= 1'b0;
    end else begin
      hist0_q <= sync2_q;
      hist1_q <= hist0_q;
      filt_q  <= (sync2_q & hist0_q) | (sync2_q & hist1_q) | (hist0_q & hist1_q);
    end
  end
  assign line = filt_q;
`else
  assign line = sync2_q;
`endif

  assign rise    = line & ~line_prev_q;
  assign fall    = ~line & line_prev_q;
  assign cnt_inc = (cnt_q == 12'hFFF) ? cnt_q : cnt_q + 12'd1;
  assign idx_inc = (idx_q == 8'hFF) ? idx_q : idx_q + 8'd1;
  assign bit_val = (cnt_q >= THRESH_M1);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_SYNC;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_SYNC: if (!line && cnt_q >= LATCH_M1) state_d = ST_IDLE;
      ST_IDLE: if (rise) state_d = ST_HIGH;
      ST_HIGH: begin
        if (cnt_q >= MAX_HIGH) state_d = ST_SYNC;
        else if (fall)         state_d = ST_LOW;
      end
      ST_LOW: begin
        if (rise)                   state_d = ST_HIGH;
        else if (cnt_q >= LATCH_M2) state_d = ST_IDLE;
      end
      default: state_d = ST_SYNC;
    endcase
  end

  // Datapath / output logic
  always_comb begin
    cnt_d         = cnt_q;
    shift_d       = shift_q;
    bit_cnt_d     = bit_cnt_q;
    idx_d         = idx_q;
    pixel_data_d  = pixel_data_q;
    pixel_valid_d = 1'b0;
    pixel_index_d = pixel_index_q;
    frame_done_d  = 1'b0;
    pixel_count_d = pixel_count_q;
    error_d       = error_q;
    unique case (state_q)
      ST_SYNC: begin
        // Any high sample restarts the search for a full latch gap.
        cnt_d     = line ? 12'd0 : cnt_inc;
        bit_cnt_d = 5'd0;
        idx_d     = 8'd0;
      end
      ST_IDLE: begin
        if (rise) cnt_d = 12'd0;
      end
      ST_HIGH: begin
        if (cnt_q >= MAX_HIGH) begin
          // Over-long high: drop the frame in flight and resynchronise.
          error_d   = 1'b1;
          bit_cnt_d = 5'd0;
          idx_d     = 8'd0;
          cnt_d     = 12'd0;
        end else if (fall) begin
          cnt_d   = 12'd0;
          shift_d = {shift_q[21:0], bit_val};
          if (bit_cnt_q == 5'd23) begin
            pixel_data_d  = {shift_q, bit_val};
            pixel_valid_d = 1'b1;
            pixel_index_d = idx_q;
            idx_d         = idx_inc;
            bit_cnt_d     = 5'd0;
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_LOW: begin
        if (rise) begin
          cnt_d = 12'd0;
        end else if (cnt_q >= LATCH_M2) begin
          // Latch gap: close the frame; a dangling partial pixel is an error for the next frame.
          frame_done_d  = 1'b1;
          pixel_count_d = idx_q;
          idx_d         = 8'd0;
          error_d       = (bit_cnt_q != 5'd0);
          bit_cnt_d     = 5'd0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      line_prev_q   <= 1'b0;
      cnt_q         <= 12'd0;
      shift_q       <= 23'd0;
      bit_cnt_q     <= 5'd0;
      idx_q         <= 8'd0;
      pixel_data_q  <= 24'd0;
      pixel_valid_q <= 1'b0;
      pixel_index_q <= 8'd0;
      frame_done_q  <= 1'b0;
      pixel_count_q <= 8'd0;
      error_q       <= 1'b0;
    end else begin
      line_prev_q   <= line;
      cnt_q         <= cnt_d;
      shift_q       <= shift_d;
      bit_cnt_q     <= bit_cnt_d;
      idx_q         <= idx_d;
      pixel_data_q  <= pixel_data_d;
      pixel_valid_q <= pixel_valid_d;
      pixel_index_q <= pixel_index_d;
      frame_done_q  <= frame_done_d;
      pixel_count_q <= pixel_count_d;
      error_q       <= error_d;
    end
  end

  assign pixel_data  = pixel_data_q;
  assign pixel_valid = pixel_valid_q;
  assign pixel_index = pixel_index_q;
  assign frame_done  = frame_done_q;
  assign pixel_count = pixel_count_q;
  assign error       = error_q;

endmodule

// File: tb/tb_neopixel_rx.sv
module tb_neopixel_rx;
  localparam int THRESH = 32;
  localparam int MAXH   = 60;
  localparam int LATCH  = 2500;
`ifdef NEOPIXEL_RX_GLITCH_FILTER_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 3;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        one_wire;
  logic [23:0] pixel_data;
  logic        pixel_valid;
  logic [7:0]  pixel_index;
  logic        frame_done;
  logic [7:0]  pixel_count;
  logic        error;

  neopixel_rx #(.BIT_THRESH_CYCLES(THRESH), .MAX_HIGH_CYCLES(MAXH), .LATCH_CYCLES(LATCH)) dut (
    .clk(clk), .reset_n(reset_n), .one_wire(one_wire),
    .pixel_data(pixel_data), .pixel_valid(pixel_valid), .pixel_index(pixel_index),
    .frame_done(frame_done), .pixel_count(pixel_count), .error(error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  int last_fall = 0;

  // Observed events, appended by the monitor only
  logic [23:0] got_pix[$];
  int          got_idx[$];
  int          got_lat[$];
  int          got_fdc[$];
  int          got_fde[$];

  always @(negedge clk) begin
    if (pixel_valid) begin
      got_pix.push_back(pixel_data);
      got_idx.push_back(int'(pixel_index));
      got_lat.push_back(cyc - last_fall);
    end
    if (frame_done) begin
      got_fdc.push_back(int'(pixel_count));
      got_fde.push_back(int'(error));
    end
  end

  // Reference model: pulses -> bits by high-time, bits -> 24-bit words, long low -> frame end
  logic [23:0] exp_pix[$];
  int          exp_idx[$];
  int          exp_fdc[$];
  int          exp_fde[$];
  int          m_nbits = 0;
  logic [23:0] m_word  = '0;
  int          m_idx   = 0;
  bit          m_err   = 1'b0;
  bit          m_active = 1'b0;
  int          cur_low = 0;
  int          pix_rd = 0;
  int          fd_rd  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_bit(input int h);
    if (h > MAXH) begin
      m_err = 1'b1; m_nbits = 0; m_idx = 0; m_active = 1'b0;
    end else begin
      m_word = {m_word[22:0], (h >= THRESH)};
      m_nbits++;
      m_active = 1'b1;
      if (m_nbits == 24) begin
        exp_pix.push_back(m_word);
        exp_idx.push_back(m_idx);
        if (m_idx < 255) m_idx++;
        m_nbits = 0;
      end
    end
  endtask

  task automatic model_low(input int l);
    if (l >= LATCH && m_active) begin
      exp_fdc.push_back(m_idx);
      m_err = (m_nbits != 0);
      exp_fde.push_back(int'(m_err));
      m_idx = 0; m_nbits = 0; m_active = 1'b0;
    end
  endtask

  task automatic pulse(input int h, input int l);
    model_bit(h);
    one_wire = 1'b1;
    repeat (h) @(posedge clk);
    #1;
    one_wire = 1'b0;
    last_fall = cyc;
    repeat (l) @(posedge clk);
    #1;
    cur_low = l;
    model_low(l);
  endtask

  task automatic gap(input int n);
    repeat (n) @(posedge clk);
    #1;
    cur_low += n;
    model_low(cur_low);
  endtask

  task automatic send_pixel(input logic [23:0] w, input int h0, input int h1, input int per);
    for (int b = 23; b >= 0; b--) pulse(w[b] ? h1 : h0, per - (w[b] ? h1 : h0));
  endtask

  // High h1, one-cycle low glitch, high h2, then low l
  task automatic glitch_bit(input int h1, input int h2, input int l);
`ifdef NEOPIXEL_RX_GLITCH_FILTER_EN
    model_bit(h1 + 1 + h2);
`else
    model_bit(h1);
    model_low(1);
    model_bit(h2);
`endif
    one_wire = 1'b1;
    repeat (h1) @(posedge clk);
    #1; one_wire = 1'b0;
    @(posedge clk);
    #1; one_wire = 1'b1;
    repeat (h2) @(posedge clk);
    #1; one_wire = 1'b0;
    last_fall = cyc;
    repeat (l) @(posedge clk);
    #1;
    cur_low = l;
    model_low(l);
  endtask

  task automatic check_scn(input string tag);
    int ngot = got_pix.size() - pix_rd;
    int nfd  = got_fdc.size() - fd_rd;
    chk({tag, ":npix"}, ngot, exp_pix.size());
    for (int i = 0; i < exp_pix.size() && i < ngot; i++) begin
      chk($sformatf("%s:data%0d", tag, i), got_pix[pix_rd + i], exp_pix[i]);
      chk($sformatf("%s:idx%0d", tag, i), got_idx[pix_rd + i], exp_idx[i]);
    end
    chk({tag, ":nframe"}, nfd, exp_fdc.size());
    for (int i = 0; i < exp_fdc.size() && i < nfd; i++) begin
      chk($sformatf("%s:count%0d", tag, i), got_fdc[fd_rd + i], exp_fdc[i]);
      chk($sformatf("%s:fderr%0d", tag, i), got_fde[fd_rd + i], exp_fde[i]);
    end
    chk({tag, ":error"}, error, m_err);
    pix_rd += ngot;
    fd_rd  += nfd;
    exp_pix.delete(); exp_idx.delete(); exp_fdc.delete(); exp_fde.delete();
  endtask

  initial begin
    logic [23:0] w;
    one_wire = 1'b0;
    reset_n  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst:pixel_valid", pixel_valid, 0);
    chk("rst:pixel_data", pixel_data, 0);
    chk("rst:pixel_index", pixel_index, 0);
    chk("rst:frame_done", frame_done, 0);
    chk("rst:pixel_count", pixel_count, 0);
    chk("rst:error", error, 0);
    reset_n = 1'b1;

    // Idle line: sync gap, no frame_done without bits
    repeat (2600) @(posedge clk);
    #1;
    check_scn("idle");

    // Single pixel, nominal timing
    send_pixel(24'h12AB34, 20, 40, 62);
    gap(2510);
    if (got_pix.size() > pix_rd) begin
      chk("s1:data_const", got_pix[pix_rd], 24'h12AB34);
      chk("s1:latency", got_lat[pix_rd], LAT);
    end
    if (got_fdc.size() > fd_rd) chk("s1:count_const", got_fdc[fd_rd], 1);
    check_scn("s1");

    // Three pixels
    send_pixel(24'hFF0000, 20, 40, 62);
    send_pixel(24'h00FF00, 20, 40, 62);
    send_pixel(24'h0000FF, 20, 40, 62);
    gap(2510);
    check_scn("s2");

    // Threshold and max-high boundaries: 31/32 alternating, then 60 and 1
    for (int i = 0; i < 22; i++) pulse((i % 2) ? 32 : 31, 30);
    pulse(60, 30);
    pulse(1, 30);
    gap(2510);
    if (got_pix.size() > pix_rd) chk("s3:data_const", got_pix[pix_rd], 24'h555556);
    check_scn("s3");

    // Over-long high -> error, no pixel, no frame_done
    pulse(70, 2600);
    chk("s4a:error_const", error, 1);
    check_scn("s4a");
    send_pixel(24'($urandom), 20, 40, 62);
    gap(2510);
    check_scn("s4b");

    // Partial pixel then latch
    for (int i = 0; i < 10; i++) pulse(($urandom_range(0, 1) == 1) ? 40 : 20, 22);
    gap(2510);
    check_scn("s5");

    // Random timing within legal ranges
    for (int p = 0; p < 3; p++) begin
      w = 24'($urandom);
      for (int b = 23; b >= 0; b--)
        pulse(w[b] ? int'($urandom_range(32, 60)) : int'($urandom_range(2, 31)), int'($urandom_range(2, 40)));
    end
    gap(2510);
    check_scn("s6");

    // Glitch inside a long high
    w = 24'($urandom);
    for (int b = 23; b >= 2; b--) pulse(w[b] ? 40 : 20, w[b] ? 22 : 42);
    glitch_bit(20, 19, 40);
`ifdef NEOPIXEL_RX_GLITCH_FILTER_EN
    pulse(40, 22);
`endif
    gap(2510);
    check_scn("s7");

    // Index saturation
    for (int p = 0; p < 257; p++) send_pixel(24'h000000, 2, 33, 4);
    send_pixel(24'($urandom), 2, 33, 37);
    gap(2510);
    if (got_fdc.size() > fd_rd) chk("s8:count_sat", got_fdc[fd_rd], 255);
    check_scn("s8");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
